// File: rtl/wash_cycle_sequencer.sv
// Wash-cycle phase sequencer: FILL -> WASH -> RINSE -> (WASH -> RINSE) -> SPIN -> IDLE.
// Phase timing is in seconds of a clock whose rate is latched from clk_freq when the coin is taken.
module wash_cycle_sequencer #(
    parameter int unsigned FILL_SEC  = 60,
    parameter int unsigned WASH_SEC  = 300,
    parameter int unsigned RINSE_SEC = 120,
    parameter int unsigned SPIN_SEC  = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] clk_freq,
    input  logic       coin_in,
    input  logic       double_wash,
    input  logic       timer_pause,
    output logic [2:0] state_o,
    output logic       busy,
    output logic       paused,
    output logic       wash_done
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFill  = 3'd1,
        StWash  = 3'd2,
        StRinse = 3'd3,
        StSpin  = 3'd4
    } state_e;

    state_e     r_state;
    logic [1:0] r_freq;
    logic       r_dbl;
    logic       r_second;
    logic [2:0] r_presc;
    logic [8:0] r_sec;
    logic       r_paused;
    logic       r_wash_done;

    logic [2:0] w_presc_max;
    logic [8:0] w_dur_m1;
    logic       w_tick;
    logic       w_end;

    always_comb begin
        w_presc_max = 3'd0;
        unique case (r_freq)
            2'd0: w_presc_max = 3'd0;
            2'd1: w_presc_max = 3'd1;
            2'd2: w_presc_max = 3'd3;
            2'd3: w_presc_max = 3'd7;
            default: w_presc_max = 3'd0;
        endcase
    end

    always_comb begin
        w_dur_m1 = 9'd0;
        case (r_state)
            StFill:  w_dur_m1 = 9'(FILL_SEC - 1);
            StWash:  w_dur_m1 = 9'(WASH_SEC - 1);
            StRinse: w_dur_m1 = 9'(RINSE_SEC - 1);
            StSpin:  w_dur_m1 = 9'(SPIN_SEC - 1);
            default: w_dur_m1 = 9'd0;
        endcase
    end

    assign w_tick = (r_presc == w_presc_max);
    assign w_end  = w_tick && (r_sec == w_dur_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_freq      <= 2'd0;
            r_dbl       <= 1'b0;
            r_second    <= 1'b0;
            r_presc     <= 3'd0;
            r_sec       <= 9'd0;
            r_paused    <= 1'b0;
            r_wash_done <= 1'b0;
        end else begin
            r_paused    <= 1'b0;
            r_wash_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (coin_in) begin
                        r_state  <= StFill;
                        r_freq   <= clk_freq;
                        r_dbl    <= double_wash;
                        r_second <= 1'b0;
                        r_presc  <= 3'd0;
                        r_sec    <= 9'd0;
                    end
                end
                StFill, StWash, StRinse, StSpin: begin
                    if (r_state == StSpin && timer_pause) begin
                        // Frozen: counters hold, so no phase end can fire.
                        r_paused <= 1'b1;
                    end else if (w_end) begin
                        r_presc <= 3'd0;
                        r_sec   <= 9'd0;
                        case (r_state)
                            StFill: r_state <= StWash;
                            StWash: r_state <= StRinse;
                            StRinse: begin
                                if (r_dbl && !r_second) begin
                                    r_state  <= StWash;
                                    r_second <= 1'b1;
                                end else begin
                                    r_state <= StSpin;
                                end
                            end
                            default: begin
                                r_state     <= StIdle;
                                r_wash_done <= 1'b1;
                            end
                        endcase
                    end else if (w_tick) begin
                        r_presc <= 3'd0;
                        r_sec   <= r_sec + 9'd1;
                    end else begin
                        r_presc <= r_presc + 3'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_presc <= 3'd0;
                    r_sec   <= 9'd0;
                end
            endcase
        end
    end

    assign state_o   = r_state;
    assign busy      = (r_state != StIdle);
    assign paused    = r_paused;
    assign wash_done = r_wash_done;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench for wash_cycle_sequencer: per-cycle expected outputs are queued
// when a coin is driven and popped one per clock for comparison.
module tb_wash_cycle_sequencer;

    localparam int unsigned FillS  = 2;
    localparam int unsigned WashS  = 3;
    localparam int unsigned RinseS = 2;
    localparam int unsigned SpinS  = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] clk_freq;
    logic       coin_in;
    logic       double_wash;
    logic       timer_pause;
    logic [2:0] state_o;
    logic       busy;
    logic       paused;
    logic       wash_done;

    typedef struct packed {
        logic [2:0] st;
        logic       busy;
        logic       paused;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;

    wash_cycle_sequencer #(
        .FILL_SEC  (FillS),
        .WASH_SEC  (WashS),
        .RINSE_SEC (RinseS),
        .SPIN_SEC  (SpinS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_freq    (clk_freq),
        .coin_in     (coin_in),
        .double_wash (double_wash),
        .timer_pause (timer_pause),
        .state_o     (state_o),
        .busy        (busy),
        .paused      (paused),
        .wash_done   (wash_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [2:0] st, input int n, input logic p);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.st     = st;
            e.busy   = (st != 3'd0);
            e.paused = p;
            e.done   = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic push_done();
        exp_t e;
        e = '{st: 3'd0, busy: 1'b0, paused: 1'b0, done: 1'b1};
        q.push_back(e);
    endtask

    task automatic push_cycle(input int freq, input logic dbl);
        int m;
        m = 1 << freq;
        push(3'd1, FillS * m, 1'b0);
        push(3'd2, WashS * m, 1'b0);
        push(3'd3, RinseS * m, 1'b0);
        if (dbl) begin
            push(3'd2, WashS * m, 1'b0);
            push(3'd3, RinseS * m, 1'b0);
        end
        push(3'd4, SpinS * m, 1'b0);
        push_done();
    endtask

    task automatic compare(input string tag, input exp_t got, input exp_t exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed st=%0d busy=%b paused=%b done=%b expected st=%0d busy=%b paused=%b done=%b",
                   tag, got.st, got.busy, got.paused, got.done,
                   exp.st, exp.busy, exp.paused, exp.done);
        end
    endtask

    task automatic step_check(input string tag);
        exp_t got;
        exp_t exp;
        @(posedge clk);
        #1;
        got = {state_o, busy, paused, wash_done};
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: scoreboard empty, observed st=%0d", tag, got.st);
        end else begin
            exp = q.pop_front();
            compare(tag, got, exp);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = q.size();
        for (int i = 0; i < n; i++) begin
            if (i == 1) coin_in = 1'b0;
            step_check(tag);
        end
    endtask

    initial begin
        exp_t zero;
        exp_t got;
        zero = '0;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        clk_freq = 2'd0;
        coin_in = 1'b0;
        double_wash = 1'b0;
        timer_pause = 1'b0;

        #2;
        got = {state_o, busy, paused, wash_done};
        compare("reset_state", got, zero);
        @(negedge clk);
        rst_n = 1'b1;
        push(3'd0, 2, 1'b0);
        drain("idle_after_reset");

        // 1 Hz single cycle
        clk_freq = 2'd0;
        coin_in = 1'b1;
        push_cycle(0, 1'b0);
        push(3'd0, 1, 1'b0);
        drain("run_1hz");

        // 8 Hz single cycle
        clk_freq = 2'd3;
        coin_in = 1'b1;
        push_cycle(3, 1'b0);
        drain("run_8hz");

        // Double wash with clk_freq/double_wash changes and stray coins mid-cycle
        clk_freq = 2'd0;
        double_wash = 1'b1;
        coin_in = 1'b1;
        push_cycle(0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            if (i == 1) begin
                coin_in = 1'b0;
                clk_freq = 2'd3;
                double_wash = 1'b0;
            end
            if (i == 3) coin_in = 1'b1;
            if (i == 5) coin_in = 1'b0;
            if (i == 8) clk_freq = 2'd0;
            step_check("double_wash");
        end

        // Coin in the wash_done cycle starts a new cycle
        coin_in = 1'b1;
        push(3'd1, FillS, 1'b0);
        push(3'd2, WashS, 1'b0);
        push(3'd3, RinseS, 1'b0);
        push(3'd4, 1, 1'b0);
        push(3'd4, 5, 1'b1);
        push(3'd4, SpinS - 1, 1'b0);
        push_done();
        push(3'd0, 1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 1) coin_in = 1'b0;
            if (i == 3) timer_pause = 1'b1;
            if (i == 5) timer_pause = 1'b0;
            if (i == 8) timer_pause = 1'b1;
            if (i == 13) timer_pause = 1'b0;
            step_check("b2b_pause");
        end

        // Asynchronous reset mid-RINSE
        coin_in = 1'b1;
        push(3'd1, FillS, 1'b0);
        push(3'd2, WashS, 1'b0);
        push(3'd3, 1, 1'b0);
        drain("pre_reset");
        #3;
        rst_n = 1'b0;
        #1;
        got = {state_o, busy, paused, wash_done};
        compare("async_reset", got, zero);
        @(posedge clk);
        #1;
        got = {state_o, busy, paused, wash_done};
        compare("held_reset", got, zero);
        @(negedge clk);
        rst_n = 1'b1;
        coin_in = 1'b1;
        push_cycle(0, 1'b0);
        drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
